// File: rtl/hanoi_move_gen.sv
// hanoi_move_gen: iterative Tower of Hanoi move source.
// Emits the optimal 2^S-1 move sequence ({fr,to,disk}) from peg 0 to peg TGT,
// one move per valid/ready transfer.
// Optional feature macro: HANOI_GEN_CHECK_EN (shadow peg masks drive err).
//
// Handshake: a move transfers on a rising edge where mv_valid & mv_ready.
// While mv_valid is high and mv_ready is low, fr/to/disk/move_cnt are held.
// mv_valid only falls after a transfer, or on reset.
// The FSM state is visible through busy (RUN) and done (DONE after the last move).
module hanoi_move_gen #(
    parameter int S   = 4,
    parameter int TGT = 2,
    localparam int DW = ($clog2(S) > 0) ? $clog2(S) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    output logic          mv_valid,
    input  logic          mv_ready,
    output logic [1:0]    fr,
    output logic [1:0]    to,
    output logic [DW-1:0] disk,
    output logic [S-1:0]  move_cnt,
    output logic          busy,
    output logic          done,
    output logic          err
);

    if (S < 1 || S > 8) begin : g_bad_s
        $error("hanoi_move_gen: S must be in 1..8");
    end
    if (TGT != 1 && TGT != 2) begin : g_bad_tgt
        $error("hanoi_move_gen: TGT must be 1 or 2");
    end

    // The plain index formulas land the stack on peg 2 for odd S, peg 1 for even S.
    localparam int     NATIVE = (S % 2 == 1) ? 2 : 1;
    localparam bit     SWAP   = (NATIVE != TGT);
    localparam logic [S-1:0] LAST = {S{1'b1}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t         state, state_nxt;
    logic [S-1:0]   m;
    logic [S-1:0]   m_next;
    logic [1:0]     dec_fr, dec_to;
    logic [DW-1:0]  dec_disk;
    logic           xfer;
    logic           launch;

    function automatic logic [1:0] map_peg(input logic [1:0] p);
        logic [1:0] r;
        r = p;
        if (SWAP) begin
            if (p == 2'd1) r = 2'd2;
            else if (p == 2'd2) r = 2'd1;
        end
        return r;
    endfunction

    function automatic logic [DW-1:0] trailing_zeros(input logic [S-1:0] v);
        logic [DW-1:0] r;
        r = '0;
        for (int i = S - 1; i >= 0; i--) begin
            if (v[i]) r = DW'(i);
        end
        return r;
    endfunction

    assign busy     = (state == RUN);
    assign mv_valid = busy;
    assign xfer     = busy & mv_ready;
    assign launch   = (state != RUN) & start;

    // Decode the move that will be presented next (index 1 on launch, m+1 in RUN).
    always_comb begin
        logic [S:0] mx;
        logic [S:0] a;
        logic [S:0] b;
        m_next   = (state == RUN) ? m + S'(1) : S'(1);
        mx       = {1'b0, m_next};
        a        = mx & (mx - (S+1)'(1));
        b        = (mx | (mx - (S+1)'(1))) + (S+1)'(1);
        dec_fr   = map_peg(2'(a % 3));
        dec_to   = map_peg(2'(b % 3));
        dec_disk = trailing_zeros(m_next);
    end

    // Next-state logic: IDLE/DONE launch on start, RUN ends on the last transfer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE, DONE: if (start) state_nxt = RUN;
            RUN:        if (xfer && m == LAST) state_nxt = DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // State, move index and registered move outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            m        <= '0;
            fr       <= '0;
            to       <= '0;
            disk     <= '0;
            move_cnt <= '0;
            done     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (launch) begin
                m        <= S'(1);
                move_cnt <= '0;
                done     <= 1'b0;
                fr       <= dec_fr;
                to       <= dec_to;
                disk     <= dec_disk;
            end else if (xfer) begin
                move_cnt <= move_cnt + S'(1);
                if (m == LAST) begin
                    done <= 1'b1;
                end else begin
                    m    <= m_next;
                    fr   <= dec_fr;
                    to   <= dec_to;
                    disk <= dec_disk;
                end
            end
        end
    end

`ifdef HANOI_GEN_CHECK_EN
    logic [S-1:0] peg [3];
    logic [S-1:0] src, dst, bitm, src_low;
    logic         bad;

    always_comb begin
        src     = peg[fr];
        dst     = peg[to];
        bitm    = S'(1) << disk;
        src_low = src & (~src + S'(1));
        bad     = (src_low != bitm) || ((dst & (bitm - S'(1))) != '0);
    end

    // Shadow peg masks: flag any transfer that is not a legal Hanoi move.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            peg[0] <= '1;
            peg[1] <= '0;
            peg[2] <= '0;
            err    <= 1'b0;
        end else if (launch) begin
            peg[0] <= '1;
            peg[1] <= '0;
            peg[2] <= '0;
            err    <= 1'b0;
        end else if (xfer) begin
            if (bad) err <= 1'b1;
            peg[fr] <= peg[fr] & ~bitm;
            peg[to] <= peg[to] | bitm;
        end
    end
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_hanoi_move_gen.sv
// Directed bench for hanoi_move_gen: S=4/TGT=2 main instance plus an S=3/TGT=2 instance.
module tb_hanoi_move_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mv_ready;
    logic       mv_valid;
    logic [1:0] fr, to;
    logic [1:0] disk;
    logic [3:0] move_cnt;
    logic       busy, done, err;

    logic       start3;
    logic       mv_ready3;
    logic       mv_valid3;
    logic [1:0] fr3, to3;
    logic [1:0] disk3;
    logic [2:0] move_cnt3;
    logic       busy3, done3, err3;

    int errors = 0;
    int checks = 0;

    logic [5:0] exp_q[$];

    logic [1:0] e4_fr [15] = '{2'd0,2'd0,2'd1,2'd0,2'd2,2'd2,2'd0,2'd0,2'd1,2'd1,2'd2,2'd1,2'd0,2'd0,2'd1};
    logic [1:0] e4_to [15] = '{2'd1,2'd2,2'd2,2'd1,2'd0,2'd1,2'd1,2'd2,2'd2,2'd0,2'd0,2'd2,2'd1,2'd2,2'd2};
    logic [1:0] e4_dk [15] = '{2'd0,2'd1,2'd0,2'd2,2'd0,2'd1,2'd0,2'd3,2'd0,2'd1,2'd0,2'd2,2'd0,2'd1,2'd0};
    logic [1:0] e3_fr [7]  = '{2'd0,2'd0,2'd2,2'd0,2'd1,2'd1,2'd0};
    logic [1:0] e3_to [7]  = '{2'd2,2'd1,2'd1,2'd2,2'd0,2'd2,2'd2};
    logic [1:0] e3_dk [7]  = '{2'd0,2'd1,2'd0,2'd2,2'd0,2'd1,2'd0};

    hanoi_move_gen #(.S(4), .TGT(2)) dut (
        .clk(clk), .rst(rst), .start(start), .mv_valid(mv_valid), .mv_ready(mv_ready),
        .fr(fr), .to(to), .disk(disk), .move_cnt(move_cnt), .busy(busy), .done(done), .err(err)
    );

    hanoi_move_gen #(.S(3), .TGT(2)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .mv_valid(mv_valid3), .mv_ready(mv_ready3),
        .fr(fr3), .to(to3), .disk(disk3), .move_cnt(move_cnt3), .busy(busy3), .done(done3), .err(err3)
    );

    // Clock and reset
    always #5 clk = ~clk;

    task automatic do_start();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic load_q4();
        exp_q.delete();
        for (int i = 0; i < 15; i++) exp_q.push_back({e4_fr[i], e4_to[i], e4_dk[i]});
    endtask

    // Walks the S=4 sequence from the current negedge; optional stall on move index
    // stall_at (3 cycles) and an extra start pulse when cnt == start_at.
    task automatic run_moves(input int stall_at, input int start_at);
        int cnt = 0;
        int stalls = 0;
        int cycles = 0;
        bit pulsed = 1'b0;
        logic [5:0] e;
        load_q4();
        while (exp_q.size() > 0 && cycles < 200) begin
            cycles++;
            mv_ready = !(cnt == stall_at && stalls < 3);
            if (!mv_ready) stalls++;
            start = (cnt == start_at && !pulsed);
            if (start) pulsed = 1'b1;
            e = exp_q[0];
            checks++;
            if (mv_valid !== 1'b1) begin
                errors++; $display("FAIL valid m%0d: got %b want 1", cnt + 1, mv_valid);
            end
            checks++;
            if ({fr, to, disk} !== e) begin
                errors++; $display("FAIL move m%0d: got %0d->%0d d%0d want %0d->%0d d%0d",
                                   cnt + 1, fr, to, disk, e[5:4], e[3:2], e[1:0]);
            end
            checks++;
            if (move_cnt !== 4'(cnt)) begin
                errors++; $display("FAIL move_cnt m%0d: got %0d want %0d", cnt + 1, move_cnt, cnt);
            end
            if (mv_ready) begin
                void'(exp_q.pop_front());
                cnt++;
            end
            @(negedge clk);
        end
        start = 1'b0;
        mv_ready = 1'b1;
        checks++;
        if (cycles >= 200) begin
            errors++; $display("FAIL run budget: got %0d moves want 15", cnt);
        end
        checks++;
        if ({mv_valid, busy, done, move_cnt} !== {1'b0, 1'b0, 1'b1, 4'd15}) begin
            errors++; $display("FAIL end state: got valid=%b busy=%b done=%b cnt=%0d want 0 0 1 15",
                               mv_valid, busy, done, move_cnt);
        end
        checks++;
        if ({fr, to, disk} !== {2'd1, 2'd2, 2'd0}) begin
            errors++; $display("FAIL last move held: got %0d->%0d d%0d want 1->2 d0", fr, to, disk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; mv_ready = 1'b1; start3 = 1'b0; mv_ready3 = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if ({mv_valid, fr, to, disk, move_cnt, busy, done, err} !== 14'd0) begin
            errors++; $display("FAIL reset outputs: got %b want 0", {mv_valid, fr, to, disk, move_cnt, busy, done, err});
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({mv_valid, busy, done} !== 3'b000) begin
            errors++; $display("FAIL idle without start: got %b want 000", {mv_valid, busy, done});
        end
    endtask

    task automatic test_full_run();
        do_start();
        run_moves(-1, -1);
    endtask

    task automatic test_backpressure();
        do_start();
        checks++;
        if ({done, move_cnt, busy} !== {1'b0, 4'd0, 1'b1}) begin
            errors++; $display("FAIL restart from done: got done=%b cnt=%0d busy=%b want 0 0 1", done, move_cnt, busy);
        end
        run_moves(4, -1);
    endtask

    task automatic test_start_in_run();
        do_start();
        run_moves(-1, 7);
    endtask

    task automatic test_async_reset();
        do_start();
        repeat (6) @(negedge clk);
        checks++;
        if (move_cnt !== 4'd6) begin
            errors++; $display("FAIL cnt before reset: got %0d want 6", move_cnt);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if ({mv_valid, fr, to, disk, move_cnt, busy, done, err} !== 14'd0) begin
            errors++; $display("FAIL async reset: got %b want 0", {mv_valid, fr, to, disk, move_cnt, busy, done, err});
        end
        @(negedge clk) rst = 1'b0;
        do_start();
        checks++;
        if ({mv_valid, fr, to, disk, move_cnt} !== {1'b1, 2'd0, 2'd1, 2'd0, 4'd0}) begin
            errors++; $display("FAIL replay m1: got v=%b %0d->%0d d%0d cnt=%0d want 1 0->1 d0 0",
                               mv_valid, fr, to, disk, move_cnt);
        end
        rst = 1'b1;
        @(negedge clk) rst = 1'b0;
    endtask

    task automatic test_s3();
        int peg [3];
        int cnt = 0;
        peg[0] = 7; peg[1] = 0; peg[2] = 0;
        @(negedge clk) start3 = 1'b1;
        @(negedge clk) start3 = 1'b0;
        while (cnt < 7) begin
            checks++;
            if ({mv_valid3, fr3, to3, disk3} !== {1'b1, e3_fr[cnt], e3_to[cnt], e3_dk[cnt]}) begin
                errors++; $display("FAIL s3 m%0d: got v=%b %0d->%0d d%0d want 1 %0d->%0d d%0d",
                                   cnt + 1, mv_valid3, fr3, to3, disk3, e3_fr[cnt], e3_to[cnt], e3_dk[cnt]);
            end
            peg[fr3] = peg[fr3] & ~(1 << disk3);
            peg[to3] = peg[to3] | (1 << disk3);
            cnt++;
            @(negedge clk);
        end
        checks++;
        if ({done3, busy3, mv_valid3, move_cnt3, err3} !== {3'b100, 3'd7, 1'b0}) begin
            errors++; $display("FAIL s3 end: got done=%b busy=%b v=%b cnt=%0d err=%b want 1 0 0 7 0",
                               done3, busy3, mv_valid3, move_cnt3, err3);
        end
        checks++;
        if (peg[2] !== 7 || peg[0] !== 0 || peg[1] !== 0) begin
            errors++; $display("FAIL s3 final pegs: got %0d %0d %0d want 0 0 7", peg[0], peg[1], peg[2]);
        end
    endtask

    initial begin
        test_reset();
        test_full_run();
        test_backpressure();
        test_start_in_run();
        test_async_reset();
        test_s3();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
